// File: rtl/combat_pkg.sv
// ============================================================
// Package : combat_pkg
// Brief   : Shared enemy-state / direction types and popcount helper
// Rev     : 1.0
// ============================================================
`default_nettype none

package combat_pkg;

  typedef enum logic [1:0] {
    DEAD   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2
  } enemy_state_t;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_RIGHT = 2'd3
  } direction_t;

  localparam int c_MAX_ENEMY = 8;

  function automatic logic [3:0] popcount(input logic [c_MAX_ENEMY-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < c_MAX_ENEMY; b++) begin
      n = n + {3'b000, v[b]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/attack_hitbox.sv
// ============================================================
// Module : attack_hitbox
// Brief  : Combinational overlap test of one enemy box vs the player attack box
// Rev    : 1.0
// ============================================================
`default_nettype none

module attack_hitbox
  import combat_pkg::*;
#(
  parameter int ATTACK_SHORT = 16,
  parameter int ATTACK_LONG  = 80,
  parameter int ENEMY_W      = 26,
  parameter int ENEMY_H      = 26
) (
  input  logic [8:0] Enemy_X,
  input  logic [8:0] Enemy_Y,
  input  logic [8:0] Attack_X,
  input  logic [8:0] Attack_Y,
  input  logic [1:0] Direction,
  output logic       Hit
);

  localparam logic [10:0] c_S = 11'(ATTACK_SHORT);
  localparam logic [10:0] c_L = 11'(ATTACK_LONG);
  localparam logic [10:0] c_W = 11'(ENEMY_W);
  localparam logic [10:0] c_H = 11'(ENEMY_H);

  // 11-bit operands keep every sum free of wrap-around
  logic [10:0] w_ex, w_ey, w_ax, w_ay;
  assign w_ex = {2'b00, Enemy_X};
  assign w_ey = {2'b00, Enemy_Y};
  assign w_ax = {2'b00, Attack_X};
  assign w_ay = {2'b00, Attack_Y};

  always_comb begin
    Hit = 1'b0;
    unique case (direction_t'(Direction))
      DIR_DOWN:  Hit = (w_ex + c_W >= w_ax) && (w_ex <= w_ax + c_S) &&
                       (w_ey + c_H >= w_ay) && (w_ey <= w_ay + c_L);
      DIR_LEFT:  Hit = (w_ex + c_W + c_L >= w_ax) && (w_ex <= w_ax) &&
                       (w_ey + c_H >= w_ay) && (w_ey <= w_ay + c_S);
      DIR_UP:    Hit = (w_ex + c_W >= w_ax) && (w_ex <= w_ax + c_S) &&
                       (w_ey + c_H + c_L >= w_ay) && (w_ey <= w_ay);
      DIR_RIGHT: Hit = (w_ex + c_W >= w_ax) && (w_ex <= w_ax + c_L) &&
                       (w_ey + c_H >= w_ay) && (w_ey <= w_ay + c_S);
      default:   Hit = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/enemy_combat_array.sv
// ============================================================
// Module : enemy_combat_array
// Brief  : Per-frame combat state for NUM_ENEMY enemies plus player health/score
// Rev    : 1.0
// ============================================================
`default_nettype none

module enemy_combat_array
  import combat_pkg::*;
#(
  parameter int NUM_ENEMY      = 4,
  parameter int HP_W           = 7,
  parameter int ENEMY_FULL_HP  = 100,
  parameter int PLAYER_DAMAGE  = 10,
  parameter int ENEMY_DAMAGE   = 10,
  parameter int PLAYER_FULL_HP = 1000,
  parameter int RESPAWN_BASE   = 40,
  parameter int INVULN_FRAMES  = 3,
  parameter int ATTACK_SHORT   = 16,
  parameter int ATTACK_LONG    = 80,
  parameter int ENEMY_W        = 26,
  parameter int ENEMY_H        = 26,
  parameter int SCORE_W        = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Frame_Tick,
  input  logic                      Game_Restart,
  input  logic [8:0]                Attack_X,
  input  logic [8:0]                Attack_Y,
  input  logic [1:0]                Player_Direction,
  input  logic                      Attack_On,
  input  logic [9*NUM_ENEMY-1:0]    Enemy_X,
  input  logic [9*NUM_ENEMY-1:0]    Enemy_Y,
  input  logic [NUM_ENEMY-1:0]      Enemy_Attack_On,
  output logic [NUM_ENEMY-1:0]      Enemy_Alive,
  output logic [NUM_ENEMY-1:0]      Enemy_Is_Attacked,
  output logic [HP_W*NUM_ENEMY-1:0] Enemy_HP,
  output logic [NUM_ENEMY-1:0]      Kill_Pulse,
  output logic [SCORE_W-1:0]        Score,
  output logic [9:0]                Player_HP,
  output logic                      Player_Dead
);

  localparam int c_RSP_MAX = RESPAWN_BASE * NUM_ENEMY;
  localparam int c_RSP_W   = (c_RSP_MAX > 1) ? $clog2(c_RSP_MAX) : 1;
  localparam int c_INV_W   = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [SCORE_W+3:0] c_SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

  logic                 r_player_dead;
  logic [9:0]           r_player_hp;
  logic [SCORE_W-1:0]   r_score;
  logic                 w_adv;
  logic [NUM_ENEMY-1:0] w_alive;
  logic [NUM_ENEMY-1:0] w_kill;

  // A latched game-over blocks every frame update until reset/restart
  assign w_adv = Frame_Tick & ~r_player_dead;

  for (genvar gi = 0; gi < NUM_ENEMY; gi++) begin : g_enemy
    localparam int c_RSP_LIM = RESPAWN_BASE * (gi + 1) - 1;

    enemy_state_t        r_state, w_state_nxt;
    logic [HP_W-1:0]     r_hp, w_hp_nxt;
    logic [c_RSP_W-1:0]  r_rsp, w_rsp_nxt;
    logic [c_INV_W-1:0]  r_inv, w_inv_nxt;
    logic                r_alive, r_hit_pulse, r_kill_pulse;
    logic                w_hit, w_took, w_die;

    attack_hitbox #(
      .ATTACK_SHORT (ATTACK_SHORT),
      .ATTACK_LONG  (ATTACK_LONG),
      .ENEMY_W      (ENEMY_W),
      .ENEMY_H      (ENEMY_H)
    ) u_hitbox (
      .Enemy_X   (Enemy_X[9*gi +: 9]),
      .Enemy_Y   (Enemy_Y[9*gi +: 9]),
      .Attack_X  (Attack_X),
      .Attack_Y  (Attack_Y),
      .Direction (Player_Direction),
      .Hit       (w_hit)
    );

    always_comb begin
      w_state_nxt = r_state;
      w_hp_nxt    = r_hp;
      w_rsp_nxt   = r_rsp;
      w_inv_nxt   = r_inv;
      w_took      = 1'b0;
      w_die       = 1'b0;
      if (w_adv) begin
        unique case (r_state)
          DEAD: begin
            if (r_rsp == c_RSP_W'(c_RSP_LIM)) begin
              w_state_nxt = ALIVE;
              w_hp_nxt    = HP_W'(ENEMY_FULL_HP);
              w_rsp_nxt   = '0;
            end else begin
              w_rsp_nxt = r_rsp + 1'b1;
            end
          end
          ALIVE: begin
            if (Attack_On && w_hit) begin
              w_took = 1'b1;
              if (r_hp <= HP_W'(PLAYER_DAMAGE)) begin
                w_state_nxt = DEAD;
                w_hp_nxt    = '0;
                w_die       = 1'b1;
              end else begin
                w_hp_nxt = r_hp - HP_W'(PLAYER_DAMAGE);
                if (INVULN_FRAMES != 0) begin
                  w_state_nxt = INVULN;
                  w_inv_nxt   = c_INV_W'(INVULN_FRAMES);
                end
              end
            end
          end
          INVULN: begin
            if (r_inv <= c_INV_W'(1)) begin
              w_state_nxt = ALIVE;
              w_inv_nxt   = '0;
            end else begin
              w_inv_nxt = r_inv - 1'b1;
            end
          end
          default: w_state_nxt = DEAD;
        endcase
      end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state      <= DEAD;
        r_hp         <= '0;
        r_rsp        <= '0;
        r_inv        <= '0;
        r_alive      <= 1'b0;
        r_hit_pulse  <= 1'b0;
        r_kill_pulse <= 1'b0;
      end else if (Game_Restart) begin
        r_state      <= DEAD;
        r_hp         <= '0;
        r_rsp        <= '0;
        r_inv        <= '0;
        r_alive      <= 1'b0;
        r_hit_pulse  <= 1'b0;
        r_kill_pulse <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_hp         <= w_hp_nxt;
        r_rsp        <= w_rsp_nxt;
        r_inv        <= w_inv_nxt;
        r_alive      <= (w_state_nxt != DEAD);
        r_hit_pulse  <= w_took;
        r_kill_pulse <= w_die;
      end
    end

    assign w_alive[gi]                 = r_alive;
    assign w_kill[gi]                  = w_die;
    assign Enemy_Alive[gi]             = r_alive;
    assign Enemy_Is_Attacked[gi]       = r_hit_pulse;
    assign Kill_Pulse[gi]              = r_kill_pulse;
    assign Enemy_HP[HP_W*gi +: HP_W]   = r_hp;
  end

  logic [c_MAX_ENEMY-1:0] w_atk_vec, w_kill_vec;
  logic [3:0]             w_n_atk, w_n_kill;
  logic [15:0]            w_dmg;
  logic [9:0]             w_php_nxt;
  logic [SCORE_W+3:0]     w_score_sum;

  // Damage is gated by the pre-tick alive flags, so this tick's kills still hurt
  always_comb begin
    w_atk_vec                  = '0;
    w_kill_vec                 = '0;
    w_atk_vec[NUM_ENEMY-1:0]   = Enemy_Attack_On & w_alive;
    w_kill_vec[NUM_ENEMY-1:0]  = w_kill;
  end

  assign w_n_atk     = popcount(w_atk_vec);
  assign w_n_kill    = popcount(w_kill_vec);
  assign w_dmg       = 16'(w_n_atk) * 16'(ENEMY_DAMAGE);
  assign w_php_nxt   = (w_dmg >= {6'b000000, r_player_hp}) ? '0 : (r_player_hp - w_dmg[9:0]);
  assign w_score_sum = {4'b0000, r_score} + {{SCORE_W{1'b0}}, w_n_kill};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_player_hp   <= 10'(PLAYER_FULL_HP);
      r_player_dead <= 1'b0;
      r_score       <= '0;
    end else if (Game_Restart) begin
      r_player_hp   <= 10'(PLAYER_FULL_HP);
      r_player_dead <= 1'b0;
      r_score       <= '0;
    end else if (w_adv) begin
      r_player_hp   <= w_php_nxt;
      r_player_dead <= (w_php_nxt == '0);
      r_score       <= (w_score_sum > c_SCORE_MAX) ? c_SCORE_MAX[SCORE_W-1:0]
                                                   : w_score_sum[SCORE_W-1:0];
    end
  end

  assign Score       = r_score;
  assign Player_HP   = r_player_hp;
  assign Player_Dead = r_player_dead;

endmodule

`default_nettype wire
